// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: core phase encodings, register-file write sources,
// special register indices and NZP flag bit positions.
package gpu_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'b000,
    StFetch   = 3'b001,
    StDecode  = 3'b010,
    StRequest = 3'b011,
    StWait    = 3'b100,
    StExecute = 3'b101,
    StUpdate  = 3'b110,
    StDone    = 3'b111
  } core_state_e;

  typedef enum logic [1:0] {
    MuxArithmetic = 2'b00,
    MuxMemory     = 2'b01,
    MuxConstant   = 2'b10,
    MuxReserved   = 2'b11
  } reg_input_mux_e;

  localparam int unsigned NUM_REGS       = 16;
  localparam int unsigned NUM_GPR        = 13;
  localparam int unsigned LAST_GPR       = 12;
  localparam int unsigned REG_BLOCK_IDX  = 13;
  localparam int unsigned REG_BLOCK_DIM  = 14;
  localparam int unsigned REG_THREAD_IDX = 15;

  localparam int unsigned NZP_POS  = 2;
  localparam int unsigned NZP_ZERO = 1;
  localparam int unsigned NZP_NEG  = 0;

endpackage

// File: rtl/thread_regfile.sv
// Per-thread register file: R0-R12 general purpose, R13-R15 read-only specials, NZP flags.
// Define REGFILE_ZERO_REG_EN to hardwire R0 to zero.
module thread_regfile
  import gpu_pkg::*;
#(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned THREAD_ID         = 0,
  parameter int unsigned DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rd_address,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic                 decoded_nzp_write_enable,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt,
  output logic [2:0]           nzp
);

  localparam logic [DATA_BITS-1:0] BlockDim  = DATA_BITS'(THREADS_PER_BLOCK);
  localparam logic [DATA_BITS-1:0] ThreadIdx = DATA_BITS'(THREAD_ID);

  core_state_e    state;
  reg_input_mux_e wr_src;

  assign state  = core_state_e'(core_state);
  assign wr_src = reg_input_mux_e'(decoded_reg_input_mux);

  logic [DATA_BITS-1:0] gpr_q [NUM_GPR];
  logic [DATA_BITS-1:0] block_idx_q;
  logic [DATA_BITS-1:0] rs_q, rt_q;
  logic [2:0]           nzp_q;

  // Architectural view of all 16 registers as seen by the operand read ports.
  logic [DATA_BITS-1:0] reg_view [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_GPR; i++) begin
      reg_view[i] = gpr_q[i];
    end
`ifdef REGFILE_ZERO_REG_EN
    reg_view[0] = '0;
`endif
    reg_view[REG_BLOCK_IDX]  = block_idx_q;
    reg_view[REG_BLOCK_DIM]  = BlockDim;
    reg_view[REG_THREAD_IDX] = ThreadIdx;
  end

  logic rd_writable;

`ifdef REGFILE_ZERO_REG_EN
  assign rd_writable = (decoded_rd_address <= 4'(LAST_GPR)) && (decoded_rd_address != 4'd0);
`else
  assign rd_writable = (decoded_rd_address <= 4'(LAST_GPR));
`endif

  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_src_valid;

  always_comb begin
    wr_data      = '0;
    wr_src_valid = 1'b0;
    unique case (wr_src)
      MuxArithmetic: begin
        wr_data      = alu_out;
        wr_src_valid = 1'b1;
      end
      MuxMemory: begin
        wr_data      = lsu_out;
        wr_src_valid = 1'b1;
      end
      MuxConstant: begin
        wr_data      = decoded_immediate;
        wr_src_valid = 1'b1;
      end
      default: begin
        wr_data      = '0;
        wr_src_valid = 1'b0;
      end
    endcase
  end

  logic reg_wr_en;
  logic nzp_wr_en;

  assign reg_wr_en = (state == StUpdate) && decoded_reg_write_enable && rd_writable &&
                     wr_src_valid;
  assign nzp_wr_en = (state == StUpdate) && decoded_nzp_write_enable;

  // Reads (REQUEST) and writes (UPDATE) never coincide, so no bypass path exists.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        gpr_q[i] <= '0;
      end
      block_idx_q <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      nzp_q       <= 3'b000;
    end else if (enable) begin
      block_idx_q <= block_id;
      if (state == StRequest) begin
        rs_q <= reg_view[decoded_rs_address];
        rt_q <= reg_view[decoded_rt_address];
      end
      if (reg_wr_en) begin
        gpr_q[decoded_rd_address] <= wr_data;
      end
      if (nzp_wr_en) begin
        nzp_q <= alu_out[2:0];
      end
    end
  end

  assign rs  = rs_q;
  assign rt  = rt_q;
  assign nzp = nzp_q;

endmodule

// File: tb/tb_thread_regfile.sv
// Self-checking bench for thread_regfile: directed scenarios plus randomized cycles
// compared against a behavioural register-file model.
module tb_thread_regfile;

  localparam int unsigned Tpb = 4;
  localparam int unsigned Tid = 2;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] block_id;
  logic [2:0] core_state;
  logic [3:0] rd_a, rs_a, rt_a;
  logic       reg_we;
  logic [1:0] reg_mux;
  logic [7:0] imm;
  logic       nzp_we;
  logic [7:0] alu_out, lsu_out;
  logic [7:0] rs, rt;
  logic [2:0] nzp;

  thread_regfile #(
    .THREADS_PER_BLOCK(Tpb),
    .THREAD_ID        (Tid),
    .DATA_BITS        (8)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .block_id                (block_id),
    .core_state              (core_state),
    .decoded_rd_address      (rd_a),
    .decoded_rs_address      (rs_a),
    .decoded_rt_address      (rt_a),
    .decoded_reg_write_enable(reg_we),
    .decoded_reg_input_mux   (reg_mux),
    .decoded_immediate       (imm),
    .decoded_nzp_write_enable(nzp_we),
    .alu_out                 (alu_out),
    .lsu_out                 (lsu_out),
    .rs                      (rs),
    .rt                      (rt),
    .nzp                     (nzp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural register contents and output registers.
  logic [7:0] m_regs [16];
  logic [7:0] m_rs, m_rt;
  logic [2:0] m_nzp;

  function automatic logic [7:0] m_read(input logic [3:0] a);
    if (ZeroReg && a == 4'd0) return 8'h00;
    return m_regs[a];
  endfunction

  task automatic tick(input string tag);
    logic [7:0] nrs, nrt;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 13; i++) m_regs[i] = 8'h00;
      m_regs[13] = 8'h00;
      m_regs[14] = 8'(Tpb);
      m_regs[15] = 8'(Tid);
      m_rs  = 8'h00;
      m_rt  = 8'h00;
      m_nzp = 3'b000;
    end else if (enable) begin
      nrs = m_read(rs_a);
      nrt = m_read(rt_a);
      if (core_state == 3'b011) begin
        m_rs = nrs;
        m_rt = nrt;
      end
      if (core_state == 3'b110) begin
        if (reg_we && rd_a <= 4'd12 && !(ZeroReg && rd_a == 4'd0)) begin
          if (reg_mux == 2'b00) m_regs[rd_a] = alu_out;
          else if (reg_mux == 2'b01) m_regs[rd_a] = lsu_out;
          else if (reg_mux == 2'b10) m_regs[rd_a] = imm;
        end
        if (nzp_we) m_nzp = alu_out[2:0];
      end
      m_regs[13] = block_id;
    end
    #1;
    check({tag, ".rs"}, rs, m_rs);
    check({tag, ".rt"}, rt, m_rt);
    check({tag, ".nzp"}, {5'b0, nzp}, {5'b0, m_nzp});
  endtask

  task automatic go_idle();
    core_state = 3'b000;
    reg_we     = 1'b0;
    nzp_we     = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] rd, input logic [1:0] mux, input logic [7:0] val);
    core_state = 3'b110;
    reg_we     = 1'b1;
    rd_a       = rd;
    reg_mux    = mux;
    alu_out    = (mux == 2'b00) ? val : 8'hA5;
    lsu_out    = (mux == 2'b01) ? val : 8'h5A;
    imm        = (mux == 2'b10) ? val : 8'hC3;
    tick("wr");
    go_idle();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] b);
    core_state = 3'b011;
    rs_a       = a;
    rt_a       = b;
    tick("req");
    core_state = 3'b100;
    tick("wait");
    go_idle();
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    block_id = 8'd5;
    rd_a     = 4'd0;
    rs_a     = 4'd0;
    rt_a     = 4'd0;
    reg_mux  = 2'b00;
    imm      = 8'h00;
    alu_out  = 8'h00;
    lsu_out  = 8'h00;
    go_idle();

    tick("rst");
    check("rst_rs", rs, 8'h00);
    check("rst_nzp", {5'b0, nzp}, 8'h00);
    reset = 1'b0;
    tick("idle");

    do_read(4'd13, 4'd14);
    check("r13_blk", rs, 8'd5);
    check("r14_dim", rt, 8'd4);
    do_read(4'd15, 4'd15);
    check("r15_tid", rs, 8'd2);
    check("nzp_init", {5'b0, nzp}, 8'h00);

    do_write(4'd3, 2'b10, 8'h2A);
    do_read(4'd3, 4'd3);
    check("const_rs", rs, 8'h2A);
    check("const_rt", rt, 8'h2A);

    do_write(4'd4, 2'b00, 8'h11);
    do_write(4'd5, 2'b01, 8'h77);
    do_write(4'd5, 2'b11, 8'hEE);
    do_read(4'd4, 4'd5);
    check("alu_wr", rs, 8'h11);
    check("lsu_wr_mux11", rt, 8'h77);

    core_state = 3'b110;
    nzp_we     = 1'b1;
    alu_out    = 8'b0000_0010;
    tick("nzp_set");
    check("nzp_zero", {5'b0, nzp}, 8'h02);
    nzp_we  = 1'b0;
    alu_out = 8'b0000_0100;
    tick("nzp_hold");
    check("nzp_hold", {5'b0, nzp}, 8'h02);
    go_idle();

    do_write(4'd14, 2'b10, 8'hFF);
    do_read(4'd14, 4'd14);
    check("r14_ro", rs, 8'd4);

    enable = 1'b0;
    do_write(4'd6, 2'b10, 8'h66);
    enable = 1'b1;
    do_read(4'd6, 4'd6);
    check("en_low", rs, 8'h00);

    core_state = 3'b101;
    reset      = 1'b1;
    tick("rst_exec");
    reset = 1'b0;
    check("rst_exec_nzp", {5'b0, nzp}, 8'h00);
    do_read(4'd3, 4'd13);
    check("rst_r3", rs, 8'h00);
    check("rst_r13", rt, 8'h00);

    do_write(4'd0, 2'b10, 8'h09);
    do_read(4'd0, 4'd0);
    check("r0_wr", rs, ZeroReg ? 8'h00 : 8'h09);

    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      block_id   = 8'($urandom);
      core_state = 3'($urandom_range(0, 7));
      rd_a       = 4'($urandom);
      rs_a       = 4'($urandom);
      rt_a       = 4'($urandom);
      reg_we     = 1'($urandom);
      reg_mux    = 2'($urandom);
      imm        = 8'($urandom);
      nzp_we     = 1'($urandom);
      alu_out    = 8'($urandom);
      lsu_out    = 8'($urandom);
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
